// File: rtl/usbdev_pkg.sv
// Shared types and default timing constants for the always-on USB resume generator.
package usbdev_pkg;

  typedef enum logic [1:0] {
    ResumeIdle     = 2'd0,
    ResumeWaitIdle = 2'd1,
    ResumeDriveK   = 2'd2,
    ResumeDone     = 2'd3
  } usbdev_aon_resume_state_e;

  // 5 ms of idle bus and 2 ms of K drive at the 200 kHz AON clock.
  localparam int unsigned UsbAonResumeMinIdleCycles = 1000;
  localparam int unsigned UsbAonResumeKCycles       = 400;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-stage flop synchronizer for asynchronous single-bit or bundled inputs.
module prim_flop_2sync #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1_q;
  logic [Width-1:0] stage2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= ResetValue;
      stage2_q <= ResetValue;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/usbdev_aon_resume_cnt.sv
// Saturating up-counter with synchronous clear; max_o flags the terminal value.
module usbdev_aon_resume_cnt #(
  parameter int               Width  = 12,
  parameter logic [Width-1:0] MaxVal = '1
) (
  input  logic             clk_aon_i,
  input  logic             rst_aon_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             max_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MaxVal)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign max_o = (cnt_q == MaxVal);

endmodule

// File: rtl/usbdev_aon_resume.sv
// Always-on USB remote-wakeup generator: waits for an idle (J) bus, then drives K.
// Optional macro USBDEV_AON_RESUME_SENSE_ABORT_EN aborts resume on VBUS sense loss.
module usbdev_aon_resume
  import usbdev_pkg::*;
#(
  parameter int unsigned MinIdleCycles = UsbAonResumeMinIdleCycles,
  parameter int unsigned KCycles       = UsbAonResumeKCycles,
  parameter int unsigned CntWidth      = 12
) (
  input  logic clk_aon_i,
  input  logic rst_aon_ni,
  input  logic usb_dp_i,
  input  logic usb_dn_i,
  input  logic usb_sense_i,
  input  logic usb_dppullup_en_i,
  input  logic usb_dnpullup_en_i,
  input  logic wake_detect_active_aon_i,
  input  logic remote_wake_en_aon_i,
  input  logic remote_wake_req_aon_i,
  output logic usb_dp_o,
  output logic usb_dn_o,
  output logic usb_oe_o,
  output logic resume_busy_aon_o,
  output logic resume_done_aon_o,
  output logic resume_abort_aon_o
);

  usbdev_aon_resume_state_e state_q, state_d;

  logic [1:0] pad_s;
  logic       j_sync;
  logic       sense_lost;
  logic       idle_sat, k_last;
  logic       abort_d;
  logic       oe_q, dp_q, dn_q, busy_q, done_q, abort_q;
  logic [CntWidth-1:0] idle_cnt, k_cnt;

  prim_flop_2sync #(
    .Width     (2),
    .ResetValue(2'b00)
  ) u_pad_sync (
    .clk_i (clk_aon_i),
    .rst_ni(rst_aon_ni),
    .d_i   ({usb_dp_i, usb_dn_i}),
    .q_o   (pad_s)
  );

  // J is whatever level the enabled pull-up produces, so pin flip and low speed fall out.
  assign j_sync = (pad_s[1] == usb_dppullup_en_i) && (pad_s[0] == usb_dnpullup_en_i);

`ifdef USBDEV_AON_RESUME_SENSE_ABORT_EN
  logic       sense_s;
  logic [1:0] sense_hist_q;
  logic       sense_filt_q;

  prim_flop_2sync #(
    .Width     (1),
    .ResetValue(1'b1)
  ) u_sense_sync (
    .clk_i (clk_aon_i),
    .rst_ni(rst_aon_ni),
    .d_i   (usb_sense_i),
    .q_o   (sense_s)
  );

  // Filtered sense only moves once three consecutive samples agree.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      sense_hist_q <= 2'b11;
      sense_filt_q <= 1'b1;
    end else begin
      sense_hist_q <= {sense_hist_q[0], sense_s};
      if (sense_hist_q == {2{sense_s}}) begin
        sense_filt_q <= sense_s;
      end
    end
  end

  assign sense_lost = !sense_filt_q;
`else
  logic unused_sense;
  assign unused_sense = usb_sense_i;
  assign sense_lost   = 1'b0;
`endif

  usbdev_aon_resume_cnt #(
    .Width (CntWidth),
    .MaxVal(CntWidth'(MinIdleCycles))
  ) u_idle_cnt (
    .clk_aon_i (clk_aon_i),
    .rst_aon_ni(rst_aon_ni),
    .clr_i     (!wake_detect_active_aon_i || !j_sync || (state_q == ResumeDriveK)),
    .en_i      (wake_detect_active_aon_i && j_sync && (state_q != ResumeDriveK)),
    .cnt_o     (idle_cnt),
    .max_o     (idle_sat)
  );

  usbdev_aon_resume_cnt #(
    .Width (CntWidth),
    .MaxVal(CntWidth'(KCycles - 1))
  ) u_k_cnt (
    .clk_aon_i (clk_aon_i),
    .rst_aon_ni(rst_aon_ni),
    .clr_i     (state_q != ResumeDriveK),
    .en_i      (state_q == ResumeDriveK),
    .cnt_o     (k_cnt),
    .max_o     (k_last)
  );

  logic [2*CntWidth-1:0] unused_cnt;
  assign unused_cnt = {idle_cnt, k_cnt};

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    unique case (state_q)
      ResumeIdle: begin
        if (remote_wake_req_aon_i && remote_wake_en_aon_i && wake_detect_active_aon_i) begin
          state_d = ResumeWaitIdle;
        end
      end
      ResumeWaitIdle: begin
        // Host activity while waiting means it is already resuming the link itself.
        if (!j_sync) begin
          state_d = ResumeIdle;
          abort_d = 1'b1;
        end else if (idle_sat) begin
          state_d = ResumeDriveK;
        end
      end
      ResumeDriveK: begin
        if (k_last) begin
          state_d = ResumeDone;
        end
      end
      ResumeDone: begin
        state_d = ResumeIdle;
      end
      default: state_d = ResumeIdle;
    endcase

    if (!wake_detect_active_aon_i ||
        (sense_lost && ((state_q == ResumeWaitIdle) || (state_q == ResumeDriveK)))) begin
      state_d = ResumeIdle;
      abort_d = (state_q == ResumeWaitIdle) || (state_q == ResumeDriveK);
    end
  end

  // Outputs are decoded from the next state so pads switch cleanly from flops.
  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      state_q <= ResumeIdle;
      oe_q    <= 1'b0;
      dp_q    <= 1'b0;
      dn_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_q    <= (state_d == ResumeDriveK);
      dp_q    <= (state_d == ResumeDriveK) && usb_dnpullup_en_i;
      dn_q    <= (state_d == ResumeDriveK) && usb_dppullup_en_i;
      busy_q  <= (state_d == ResumeWaitIdle) || (state_d == ResumeDriveK);
      done_q  <= (state_d == ResumeDone);
      abort_q <= abort_d;
    end
  end

  assign usb_oe_o           = oe_q;
  assign usb_dp_o           = dp_q;
  assign usb_dn_o           = dn_q;
  assign resume_busy_aon_o  = busy_q;
  assign resume_done_aon_o  = done_q;
  assign resume_abort_aon_o = abort_q;

endmodule

// File: tb/tb_usbdev_aon_resume.sv
// Self-checking bench for usbdev_aon_resume: scoreboard of expected resume outcomes.
module tb_usbdev_aon_resume;

  localparam int W = 29;

  logic clk_aon_i, rst_aon_ni;
  logic usb_dp_i, usb_dn_i, usb_sense_i;
  logic usb_dppullup_en_i, usb_dnpullup_en_i;
  logic wake_detect_active_aon_i, remote_wake_en_aon_i, remote_wake_req_aon_i;
  logic usb_dp_o, usb_dn_o, usb_oe_o;
  logic resume_busy_aon_o, resume_done_aon_o, resume_abort_aon_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int n_results = 0;
  int oe_len = 0;
  int oe_lat = 0;
  logic run_dp, run_dn, run_stable;
  int idle_drive_err = 0;
  int pulse_err = 0;
  logic prev_pulse;

  usbdev_aon_resume dut (
    .clk_aon_i               (clk_aon_i),
    .rst_aon_ni              (rst_aon_ni),
    .usb_dp_i                (usb_dp_i),
    .usb_dn_i                (usb_dn_i),
    .usb_sense_i             (usb_sense_i),
    .usb_dppullup_en_i       (usb_dppullup_en_i),
    .usb_dnpullup_en_i       (usb_dnpullup_en_i),
    .wake_detect_active_aon_i(wake_detect_active_aon_i),
    .remote_wake_en_aon_i    (remote_wake_en_aon_i),
    .remote_wake_req_aon_i   (remote_wake_req_aon_i),
    .usb_dp_o                (usb_dp_o),
    .usb_dn_o                (usb_dn_o),
    .usb_oe_o                (usb_oe_o),
    .resume_busy_aon_o       (resume_busy_aon_o),
    .resume_done_aon_o       (resume_done_aon_o),
    .resume_abort_aon_o      (resume_abort_aon_o)
  );

  // Clock and reset
  initial clk_aon_i = 1'b0;
  always #5 clk_aon_i = ~clk_aon_i;
  always @(posedge clk_aon_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Record: kind(1=done,2=abort), request-to-oe latency, oe length, dp, dn, dp/dn stable.
  function automatic logic [W-1:0] rec(input logic [1:0] kind, input int lat, input int len,
                                       input logic dp, input logic dn, input logic st);
    return {kind, 12'(lat), 12'(len), dp, dn, st};
  endfunction

  // Monitor and scoreboard
  always @(negedge clk_aon_i) begin
    if (!rst_aon_ni) begin
      oe_len = 0; oe_lat = 0; run_stable = 1'b1; prev_pulse = 1'b0;
    end else begin
      if (usb_oe_o) begin
        if (oe_len == 0) begin
          oe_lat = cyc - req_cyc;
          run_dp = usb_dp_o;
          run_dn = usb_dn_o;
        end else if (usb_dp_o !== run_dp || usb_dn_o !== run_dn) begin
          run_stable = 1'b0;
        end
        oe_len++;
      end else if (usb_dp_o || usb_dn_o) begin
        idle_drive_err++;
      end
      if ((resume_done_aon_o && resume_abort_aon_o) ||
          ((resume_done_aon_o || resume_abort_aon_o) && prev_pulse)) pulse_err++;
      prev_pulse = resume_done_aon_o || resume_abort_aon_o;
      if (resume_done_aon_o || resume_abort_aon_o) begin
        logic [W-1:0] obs, e;
        obs = rec(resume_done_aon_o ? 2'd1 : 2'd2, oe_lat, oe_len,
                  (oe_len > 0) ? run_dp : 1'b0, (oe_len > 0) ? run_dn : 1'b0, run_stable);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", obs, '0);
        end else begin
          e = exp_q.pop_front();
          check_eq("result", obs, e);
        end
        oe_len = 0; oe_lat = 0; run_stable = 1'b1;
        n_results++;
      end
    end
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_aon_i);
    #1;
  endtask

  task automatic set_j();
    usb_dp_i = usb_dppullup_en_i;
    usb_dn_i = usb_dnpullup_en_i;
  endtask

  task automatic set_k();
    usb_dp_i = !usb_dppullup_en_i;
    usb_dn_i = !usb_dnpullup_en_i;
  endtask

  task automatic request(input logic exp_busy);
    remote_wake_req_aon_i = 1'b1;
    req_cyc = cyc + 1;
    @(posedge clk_aon_i); #1;
    remote_wake_req_aon_i = 1'b0;
    check_eq("busy_after_req", W'(resume_busy_aon_o), W'(exp_busy));
  endtask

  task automatic wait_oe_len(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_aon_i); #1;
      if (oe_len >= n) break;
    end
    check_eq("oe_len_reached", W'(oe_len >= n), W'(1));
  endtask

  task automatic wait_result(input int budget);
    int start;
    logic seen;
    start = n_results;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_aon_i); #1;
      if (n_results != start) seen = 1'b1;
    end
    check_eq("result_seen", W'(seen), W'(1));
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk_aon_i); #1;
  endtask

  initial begin
    rst_aon_ni = 1'b0;
    usb_sense_i = 1'b1;
    usb_dppullup_en_i = 1'b1;
    usb_dnpullup_en_i = 1'b0;
    wake_detect_active_aon_i = 1'b1;
    remote_wake_en_aon_i = 1'b1;
    remote_wake_req_aon_i = 1'b0;
    set_j();
    cycles(3);
    check_eq("rst_oe", W'(usb_oe_o), W'(0));
    check_eq("rst_dp", W'(usb_dp_o), W'(0));
    check_eq("rst_dn", W'(usb_dn_o), W'(0));
    check_eq("rst_busy", W'(resume_busy_aon_o), W'(0));
    check_eq("rst_done", W'(resume_done_aon_o), W'(0));
    check_eq("rst_abort", W'(resume_abort_aon_o), W'(0));
    rst_aon_ni = 1'b1;

    // Saturated idle, dp pull-up: K is dp=0, dn=1 for exactly KCycles.
    cycles(1010);
    exp_q.push_back(rec(2'd1, 1, 400, 1'b0, 1'b1, 1'b1));
    request(1'b1);
    check_eq("oe_in_wait", W'(usb_oe_o), W'(0));
    @(posedge clk_aon_i); #1;
    check_eq("oe_rise", W'(usb_oe_o), W'(1));
    check_eq("k_dp", W'(usb_dp_o), W'(0));
    check_eq("k_dn", W'(usb_dn_o), W'(1));
    wait_result(600);
    check_eq("busy_after_done", W'(resume_busy_aon_o), W'(0));

    // Pins flipped: dn pull-up, K polarity inverts.
    usb_dppullup_en_i = 1'b0;
    usb_dnpullup_en_i = 1'b1;
    set_j();
    cycles(1010);
    exp_q.push_back(rec(2'd1, 1, 400, 1'b1, 1'b0, 1'b1));
    request(1'b1);
    wait_result(600);

    // Only 100 idle cycles before the request: K starts after the idle window fills.
    usb_dppullup_en_i = 1'b1;
    usb_dnpullup_en_i = 1'b0;
    set_k();
    cycles(10);
    set_j();
    cycles(100);
    exp_q.push_back(rec(2'd1, 902, 400, 1'b0, 1'b1, 1'b1));
    request(1'b1);
    wait_result(1600);

    // Host drives K 50 cycles into WAIT_IDLE: abort, no drive.
    set_k();
    cycles(5);
    set_j();
    cycles(20);
    exp_q.push_back(rec(2'd2, 0, 0, 1'b0, 1'b0, 1'b1));
    request(1'b1);
    cycles(50);
    set_k();
    wait_result(100);
    check_eq("busy_after_abort", W'(resume_busy_aon_o), W'(0));
    set_j();

    // Wake detector releases the link mid-drive.
    cycles(1010);
    exp_q.push_back(rec(2'd2, 1, 201, 1'b0, 1'b1, 1'b1));
    request(1'b1);
    wait_oe_len(200);
    @(posedge clk_aon_i); #1;
    wake_detect_active_aon_i = 1'b0;
    wait_result(50);
    wake_detect_active_aon_i = 1'b1;

    // Reset during drive drops oe without a clock edge.
    cycles(1010);
    request(1'b1);
    wait_oe_len(100);
    rst_aon_ni = 1'b0;
    #1;
    check_eq("rst_mid_oe", W'(usb_oe_o), W'(0));
    check_eq("rst_mid_busy", W'(resume_busy_aon_o), W'(0));
    cycles(2);
    rst_aon_ni = 1'b1;

    // Remote wakeup not enabled: request dropped.
    remote_wake_en_aon_i = 1'b0;
    cycles(1010);
    request(1'b0);
    cycles(3);
    check_eq("no_en_oe", W'(usb_oe_o), W'(0));
    remote_wake_en_aon_i = 1'b1;

    // Sense drops for 5 cycles during drive.
`ifdef USBDEV_AON_RESUME_SENSE_ABORT_EN
    exp_q.push_back(rec(2'd2, 1, 106, 1'b0, 1'b1, 1'b1));
`else
    exp_q.push_back(rec(2'd1, 1, 400, 1'b0, 1'b1, 1'b1));
`endif
    request(1'b1);
    wait_oe_len(100);
    @(posedge clk_aon_i); #1;
    usb_sense_i = 1'b0;
    cycles(5);
    usb_sense_i = 1'b1;
    wait_result(600);

    // Final report
    cycles(5);
    check_eq("idle_drive", W'(idle_drive_err), W'(0));
    check_eq("pulse_rules", W'(pulse_err), W'(0));
    check_eq("queue_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
